// File: rtl/rs_entry_tracker_if.sv
// rtl/rs_entry_tracker_if.sv - allocation/free/branch bus of the reservation-station tracker
interface rs_entry_tracker_if #(
    parameter int ENT_NUM     = 8,
    parameter int ENT_SEL     = 3,
    parameter int SPECTAG_LEN = 5
);
    logic                           we1;
    logic                           we2;
    logic [ENT_SEL-1:0]             went1;
    logic [ENT_SEL-1:0]             went2;
    logic [SPECTAG_LEN-1:0]         wspectag1;
    logic [SPECTAG_LEN-1:0]         wspectag2;
    logic                           free_en;
    logic [ENT_SEL-1:0]             free_ent;
    logic                           prmiss;
    logic                           prsuccess;
    logic [SPECTAG_LEN-1:0]         prtag;
    logic [ENT_NUM-1:0]             busy;
    logic [ENT_NUM*SPECTAG_LEN-1:0] entry_tag;
    logic [ENT_SEL:0]               entry_cnt;
    logic                           nearly_full;

    modport master (
        output we1, we2, went1, went2, wspectag1, wspectag2,
        output free_en, free_ent, prmiss, prsuccess, prtag,
        input  busy, entry_tag, entry_cnt, nearly_full
    );

    modport slave (
        input  we1, we2, went1, went2, wspectag1, wspectag2,
        input  free_en, free_ent, prmiss, prsuccess, prtag,
        output busy, entry_tag, entry_cnt, nearly_full
    );
endinterface

// File: rtl/rs_entry_tracker.sv
// rtl/rs_entry_tracker.sv - busy/tag occupancy tracker for one reservation station
module rs_entry_tracker #(
    parameter int ENT_NUM     = 8,
    parameter int ENT_SEL     = 3,
    parameter int SPECTAG_LEN = 5
) (
    input  logic              clk,
    input  logic              reset,
    rs_entry_tracker_if.slave bus
);
    localparam int CNT_W = ENT_SEL + 1;

    logic [ENT_NUM-1:0]     busy_q, busy_d;
    logic [SPECTAG_LEN-1:0] tag_q [ENT_NUM];
    logic [SPECTAG_LEN-1:0] tag_d [ENT_NUM];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   nf_q, nf_d;

    logic [SPECTAG_LEN-1:0] clr_mask;
    logic                   alloc1_ok;
    logic                   alloc2_ok;

    // Next-state per entry: kill beats allocate beats free beats hold;
    // slot 2 beats slot 1 when both target the same index.
    always_comb begin
        busy_d    = busy_q;
        tag_d     = tag_q;
        cnt_d     = '0;
        nf_d      = 1'b0;
        // A mispredict in the same cycle overrides any resolved-correct report.
        clr_mask  = (bus.prsuccess && !bus.prmiss) ? bus.prtag : '0;
        // Instructions squashed by this cycle's mispredict never take a slot.
        alloc1_ok = bus.we1 && !(bus.prmiss && |(bus.wspectag1 & bus.prtag));
        alloc2_ok = bus.we2 && !(bus.prmiss && |(bus.wspectag2 & bus.prtag));

        for (int i = 0; i < ENT_NUM; i++) begin
            if (bus.prmiss && |(tag_q[i] & bus.prtag)) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end else if (alloc2_ok && bus.went2 == ENT_SEL'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.wspectag2 & ~clr_mask;
            end else if (alloc1_ok && bus.went1 == ENT_SEL'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.wspectag1 & ~clr_mask;
            end else if (bus.free_en && bus.free_ent == ENT_SEL'(i)) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end else begin
                tag_d[i]  = tag_q[i] & ~clr_mask;
            end
        end

        for (int i = 0; i < ENT_NUM; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
        nf_d = (cnt_d >= CNT_W'(ENT_NUM - 1));
    end

    // State registers; reset clears every entry immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int i = 0; i < ENT_NUM; i++) begin
                tag_q[i] <= '0;
            end
            cnt_q  <= '0;
            nf_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            cnt_q  <= cnt_d;
            nf_q   <= nf_d;
        end
    end

    // Flatten the per-entry tags onto the output bus.
    always_comb begin
        bus.entry_tag = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            bus.entry_tag[i*SPECTAG_LEN +: SPECTAG_LEN] = tag_q[i];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.entry_cnt   = cnt_q;
    assign bus.nearly_full = nf_q;
endmodule

// File: tb/tb_rs_entry_tracker.sv
// tb/tb_rs_entry_tracker.sv - scoreboard bench for rs_entry_tracker
module tb_rs_entry_tracker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs_entry_tracker_if #(.ENT_NUM(8), .ENT_SEL(3), .SPECTAG_LEN(5)) bus ();

    rs_entry_tracker #(.ENT_NUM(8), .ENT_SEL(3), .SPECTAG_LEN(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [7:0]  busy;
        logic [3:0]  cnt;
        logic        nf;
        logic [39:0] tags;
    } exp_t;

    exp_t       q[$];
    int         negcnt = 0;
    int         step = 0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] et [8];

    task automatic check(input int id, input string what, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, what, act, req);
        end
    endtask

    // Monitor: at each falling edge compare every expectation due now.
    always @(negedge clk) begin
        exp_t e;
        negcnt++;
        while (q.size() > 0 && q[0].cyc <= negcnt) begin
            e = q.pop_front();
            if (e.cyc < negcnt) begin
                checks++;
                errors++;
                $display("FAIL step %0d missed: got cycle %0d expected %0d", e.id, negcnt, e.cyc);
            end else begin
                check(e.id, "busy", 40'(bus.busy), 40'(e.busy));
                check(e.id, "entry_cnt", 40'(bus.entry_cnt), 40'(e.cnt));
                check(e.id, "nearly_full", 40'(bus.nearly_full), 40'(e.nf));
                check(e.id, "entry_tag", bus.entry_tag, e.tags);
            end
        end
    end

    // Protocol watch: allocate into a busy (and not simultaneously freed) entry, or free an idle one.
    always @(posedge clk) begin
        if (reset) begin
            if (bus.we1 && !(bus.prmiss && |(bus.wspectag1 & bus.prtag)))
                assert (!bus.busy[bus.went1] || (bus.free_en && bus.free_ent == bus.went1))
                    else $error("protocol: slot 1 allocates busy entry %0d", bus.went1);
            if (bus.we2 && !(bus.prmiss && |(bus.wspectag2 & bus.prtag)))
                assert (!bus.busy[bus.went2] || (bus.free_en && bus.free_ent == bus.went2))
                    else $error("protocol: slot 2 allocates busy entry %0d", bus.went2);
            if (bus.free_en)
                assert (bus.busy[bus.free_ent])
                    else $error("protocol: free of idle entry %0d", bus.free_ent);
        end
    end

    // dly=2: state after the coming rising edge; dly=1: state before it (async reset).
    task automatic expect_state(input int dly, input logic [7:0] b, input logic [3:0] c, input logic nf);
        exp_t e;
        e.cyc  = negcnt + dly;
        e.id   = step;
        e.busy = b;
        e.cnt  = c;
        e.nf   = nf;
        for (int i = 0; i < 8; i++) e.tags[i*5 +: 5] = et[i];
        q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.we1 = 0; bus.we2 = 0; bus.went1 = 0; bus.went2 = 0;
        bus.wspectag1 = 0; bus.wspectag2 = 0;
        bus.free_en = 0; bus.free_ent = 0;
        bus.prmiss = 0; bus.prsuccess = 0; bus.prtag = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        clear_inputs();
        step++;
    endtask

    task automatic alloc1(input logic [2:0] ent, input logic [4:0] tag);
        bus.we1 = 1; bus.went1 = ent; bus.wspectag1 = tag;
    endtask

    task automatic alloc2(input logic [2:0] ent, input logic [4:0] tag);
        bus.we2 = 1; bus.went2 = ent; bus.wspectag2 = tag;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < 8; i++) et[i] = 5'd0;
        @(posedge clk); #1;
        expect_state(1, 8'h00, 0, 0);                   // reset state
        advance();
        reset = 1'b1;
        alloc1(2, 5'b00001); alloc2(5, 5'b00010);
        et[2] = 5'b00001; et[5] = 5'b00010;
        expect_state(2, 8'h24, 2, 0);
        advance();
        alloc1(0, 0); alloc2(1, 0);
        expect_state(2, 8'h27, 4, 0);
        advance();
        alloc1(3, 0); alloc2(4, 0);
        expect_state(2, 8'h3F, 6, 0);
        advance();
        alloc1(6, 0);
        expect_state(2, 8'h7F, 7, 1);                   // count 7 -> nearly_full
        advance();
        alloc2(7, 0);
        expect_state(2, 8'hFF, 8, 1);                   // full, no wrap
        advance();
        bus.free_en = 1; bus.free_ent = 3;
        expect_state(2, 8'hF7, 7, 1);
        advance();
        bus.free_en = 1; bus.free_ent = 0; alloc1(0, 5'b00001);   // allocation beats free
        et[0] = 5'b00001;
        expect_state(2, 8'hF7, 7, 1);
        advance();
        bus.free_en = 1; bus.free_ent = 1; alloc1(1, 5'b00011);
        et[1] = 5'b00011;
        expect_state(2, 8'hF7, 7, 1);
        advance();
        bus.free_en = 1; bus.free_ent = 4; alloc1(4, 5'b00100);
        et[4] = 5'b00100;
        expect_state(2, 8'hF7, 7, 1);
        advance();
        bus.prmiss = 1; bus.prtag = 5'b00010;           // kills entries 1 and 5
        bus.free_en = 1; bus.free_ent = 6;
        et[1] = 0; et[5] = 0;
        expect_state(2, 8'h95, 4, 0);
        advance();
        bus.prsuccess = 1; bus.prtag = 5'b00001; alloc1(6, 5'b00101);
        et[0] = 0; et[2] = 0; et[6] = 5'b00100;
        expect_state(2, 8'hD5, 5, 0);
        advance();
        alloc1(1, 5'b00010);
        et[1] = 5'b00010;
        expect_state(2, 8'hD7, 6, 0);
        advance();
        bus.free_en = 1; bus.free_ent = 1; alloc1(1, 5'b01000);   // squashed alloc, free wins
        bus.prmiss = 1; bus.prtag = 5'b01000;
        et[1] = 0;
        expect_state(2, 8'hD5, 5, 0);
        advance();
        bus.prmiss = 1; bus.prsuccess = 1; bus.prtag = 5'b00100;  // kills 4 and 6
        et[4] = 0; et[6] = 0;
        expect_state(2, 8'h85, 3, 0);
        advance();
        alloc1(3, 5'b00001); alloc2(3, 5'b00010);       // same index, slot 2 tag
        et[3] = 5'b00010;
        expect_state(2, 8'h8D, 4, 0);
        advance();
        alloc1(1, 0); alloc2(4, 5'b01000);              // slot 2 squashed
        bus.prmiss = 1; bus.prtag = 5'b01000;
        expect_state(2, 8'h8F, 5, 0);
        advance();
        alloc1(4, 0);
        expect_state(2, 8'h9F, 6, 0);
        advance();
        advance();
        reset = 1'b0; alloc1(5, 0);                     // async clear mid-burst
        for (int i = 0; i < 8; i++) et[i] = 5'd0;
        expect_state(1, 8'h00, 0, 0);
        advance();
        alloc1(6, 0);                                   // held in reset across an edge
        expect_state(2, 8'h00, 0, 0);
        advance();
        reset = 1'b1; alloc1(0, 0);
        expect_state(2, 8'h01, 1, 0);
        advance();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
